// File: rtl/aes128_iter_core_pkg.sv
// AES-128 primitives shared by the iterative core and its round unit.
// State layout: FIPS-197 byte order, byte 0 in bits [127:120], column-major.
package aes128_iter_core_pkg;

    localparam int NR = 10;

    typedef enum logic [2:0] {IDLE, KEYEXP, LOAD, ROUND, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0), avoids a 256-entry table
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a12, a15, a240;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a12  = gmul(gmul(a3, a3), gmul(a3, a3));
        a15  = gmul(a12, a3);
        a240 = gmul(a15, a15);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        return gmul(gmul(a240, a12), a2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] y;
        y = gf_inv(a);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Row r rotates left by r columns
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9),
                gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13),
                gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11),
                gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_column(s[127:96]), mix_column(s[95:64]),
                mix_column(s[63:32]), mix_column(s[31:0])};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_column(s[127:96]), inv_mix_column(s[95:64]),
                inv_mix_column(s[63:32]), inv_mix_column(s[31:0])};
    endfunction

    // rcon(i) is the constant used to derive round key i+1 from round key i
    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Recovers round key i from round key i+1
    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3, w3;
        {n0, n1, n2, n3} = k;
        w3 = n3 ^ n2;
        return {n0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0}, n1 ^ n0, n2 ^ n1, w3};
    endfunction

endpackage

// File: rtl/aes128_iter_core_if.sv
// Block/key/mode request channel and result channel of the AES core.
interface aes128_iter_core_if;
    logic         data_valid_in;
    logic         data_ready_out;
    logic         mode_dec_in;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         res_valid_out;
    logic         res_ready_in;
    logic [127:0] res_out;

    modport master (
        output data_valid_in, mode_dec_in, data_in, key_in, res_ready_in,
        input  data_ready_out, res_valid_out, res_out
    );

    modport slave (
        input  data_valid_in, mode_dec_in, data_in, key_in, res_ready_in,
        output data_ready_out, res_valid_out, res_out
    );
endinterface

// File: rtl/aes128_iter_core_round_unit.sv
// One combinational AES round, forward or inverse, with optional final-round form.
module aes_round_unit
    import aes128_iter_core_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    input  logic         dec,
    input  logic         last,
    output logic [127:0] state_out
);

    // Forward: SubBytes, ShiftRows, MixColumns, ARK; inverse: InvShiftRows, InvSubBytes, ARK, InvMixColumns
    always_comb begin
        state_out = '0;
        if (!dec) begin
            state_out = shift_rows(sub_bytes(state_in));
            if (!last) state_out = mix_columns(state_out);
            state_out = state_out ^ rk;
        end else begin
            state_out = inv_sub_bytes(inv_shift_rows(state_in)) ^ rk;
            if (!last) state_out = inv_mix_columns(state_out);
        end
    end

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 ECB engine: encrypt/decrypt per transaction, RPC rounds per
// cycle, single-entry {key, round key 10} cache to skip decrypt key expansion.
module aes128_iter_core
    import aes128_iter_core_pkg::*;
#(
    parameter int RPC          = 1,
    parameter int KEY_CACHE_EN = 1
) (
    input  logic               clk,
    input  logic               resetn,
    aes128_iter_core_if.slave  bus
);

    localparam int         NC      = NR / RPC;
    localparam logic [3:0] NC_LAST = 4'(NC - 1);
    localparam logic [3:0] RPC4    = 4'(RPC);
    localparam logic [3:0] NR4     = 4'(NR);

    state_t       fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         res_vld_q, cache_vld_q;
    logic [127:0] res_q;
    logic [127:0] st_q, rk_q, key_q, rk10_q;
    logic [127:0] cache_key_q, cache_rk_q;
    logic         dec_q;
    logic         rdy, accept, hit, cnt_wrap, done_now, inv_ks;
    logic [127:0] k_fin, s_fin;

    // Ready is forced low while reset is held, even though the state is already IDLE
    assign rdy      = resetn && (fsm_q == IDLE);
    assign accept   = bus.data_valid_in && rdy;
    assign hit      = (KEY_CACHE_EN != 0) && cache_vld_q && (bus.key_in == cache_key_q);
    assign cnt_wrap = (cnt_q == NC_LAST);
    assign done_now = (fsm_q == ROUND) && cnt_wrap;
    // Key schedule runs backwards only during decrypt rounds; KEYEXP always steps forward
    assign inv_ks   = dec_q && (fsm_q == ROUND);

    assign bus.data_ready_out = rdy;
    assign bus.res_valid_out  = res_vld_q;
    assign bus.res_out        = res_q;

    // Round chain: each stage derives its round key then applies one round with it
    for (genvar j = 0; j < RPC; j++) begin : g_rnd
        logic [127:0] k_in, s_in, k_out, s_out;
        logic [3:0]   ridx;

        if (j == 0) begin : g_first
            assign k_in = rk_q;
            assign s_in = st_q;
        end else begin : g_next
            assign k_in = g_rnd[j-1].k_out;
            assign s_in = g_rnd[j-1].s_out;
        end

        // ridx counts rounds 1..NR in processing order for either direction
        assign ridx  = cnt_q * RPC4 + 4'(j + 1);
        assign k_out = inv_ks ? inv_key_step(k_in, rcon(NR4 - ridx))
                              : key_step(k_in, rcon(ridx - 4'd1));

        aes_round_unit u_round (
            .state_in  (s_in),
            .rk        (k_out),
            .dec       (dec_q),
            .last      (ridx == NR4),
            .state_out (s_out)
        );
    end

    assign k_fin = g_rnd[RPC-1].k_out;
    assign s_fin = g_rnd[RPC-1].s_out;

    // Next-state and round counter
    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    fsm_d = (bus.mode_dec_in && !hit) ? KEYEXP : ROUND;
                end
            end
            KEYEXP: begin
                if (cnt_wrap) begin
                    cnt_d = '0;
                    fsm_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            LOAD: fsm_d = ROUND;
            ROUND: begin
                if (cnt_wrap) begin
                    cnt_d = '0;
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.res_ready_in) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Control state, result register and cache-valid flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fsm_q       <= IDLE;
            cnt_q       <= '0;
            res_vld_q   <= 1'b0;
            res_q       <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            if (done_now) begin
                res_vld_q   <= 1'b1;
                res_q       <= s_fin;
                cache_vld_q <= (KEY_CACHE_EN != 0);
            end else if ((fsm_q == DONE) && bus.res_ready_in) begin
                res_vld_q <= 1'b0;
            end
        end
    end

    // Cipher state, round key and cache contents; only ever read after being loaded
    always_ff @(posedge clk) begin
        if (accept) begin
            key_q  <= bus.key_in;
            dec_q  <= bus.mode_dec_in;
            rk10_q <= cache_rk_q;
            if (bus.mode_dec_in && hit) begin
                st_q <= bus.data_in ^ cache_rk_q;
                rk_q <= cache_rk_q;
            end else if (bus.mode_dec_in) begin
                st_q <= bus.data_in;
                rk_q <= bus.key_in;
            end else begin
                st_q <= bus.data_in ^ bus.key_in;
                rk_q <= bus.key_in;
            end
        end else if (fsm_q == KEYEXP) begin
            rk_q <= k_fin;
        end else if (fsm_q == LOAD) begin
            st_q   <= st_q ^ rk_q;
            rk10_q <= rk_q;
        end else if (fsm_q == ROUND) begin
            st_q <= s_fin;
            rk_q <= k_fin;
            if (cnt_wrap) begin
                cache_key_q <= key_q;
                cache_rk_q  <= dec_q ? rk10_q : k_fin;
            end
        end
    end

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed FIPS-197 test of aes128_iter_core (RPC=1) with a result scoreboard.
module tb_aes128_iter_core;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] res;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    aes128_iter_core_if bus ();

    aes128_iter_core #(.RPC(1), .KEY_CACHE_EN(1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic dec, input logic [127:0] k, input logic [127:0] d,
                        input logic [127:0] e, input int lat, input bit track);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.data_ready_out !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", 128'(bus.data_ready_out), 128'd1);
        bus.data_valid_in = 1'b1;
        bus.mode_dec_in   = dec;
        bus.key_in        = k;
        bus.data_in       = d;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.data_valid_in = 1'b0;
        bus.mode_dec_in   = 1'bx;
        bus.key_in        = 'x;
        bus.data_in       = 'x;
        if (track) sb.push_back('{e, lat});
    endtask

    task automatic wait_res(input string tag);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (bus.res_valid_out !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 128'(bus.res_valid_out), 128'd1);
        chk({tag, "_sb_pending"}, 128'(sb.size() > 0), 128'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_latency"}, 128'(cyc - acc_cyc), 128'(e.lat));
            chk({tag, "_result"}, bus.res_out, e.res);
        end
    endtask

    task automatic consume(input string tag);
        bus.res_ready_in = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready_in = 1'b0;
        chk({tag, "_valid_cleared"}, 128'(bus.res_valid_out), 128'd0);
        chk({tag, "_ready_back"}, 128'(bus.data_ready_out), 128'd1);
    endtask

    initial begin
        int seen;
        bus.data_valid_in = 1'b0;
        bus.mode_dec_in   = 1'b0;
        bus.key_in        = '0;
        bus.data_in       = '0;
        bus.res_ready_in  = 1'b0;
        resetn            = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 128'(bus.data_ready_out), 128'd0);
        chk("rst_valid", 128'(bus.res_valid_out), 128'd0);
        chk("rst_res", bus.res_out, 128'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_ready", 128'(bus.data_ready_out), 128'd1);

        // Decrypt, cold cache, then the same block again from the cache
        send(1'b1, K2, CT2, PT2, 21, 1'b1);
        wait_res("dec_cold");
        consume("dec_cold");
        send(1'b1, K2, CT2, PT2, 10, 1'b1);
        wait_res("dec_hit");
        consume("dec_hit");

        // Reset in the middle of a decrypt: no result, cache forgotten
        send(1'b1, K2, CT2, PT2, 10, 1'b0);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midrst_valid", 128'(bus.res_valid_out), 128'd0);
        chk("midrst_ready", 128'(bus.data_ready_out), 128'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.res_valid_out === 1'b1) seen++;
        end
        chk("midrst_no_result", 128'(seen), 128'd0);
        send(1'b1, K2, CT2, PT2, 21, 1'b1);
        wait_res("dec_after_rst");
        consume("dec_after_rst");

        // Encrypt fills the cache for the matching decrypt
        send(1'b0, K1, PT1, CT1, 10, 1'b1);
        wait_res("enc1");
        consume("enc1");
        send(1'b1, K1, CT1, PT1, 10, 1'b1);
        wait_res("dec_enc_key");

        // Backpressure: result held, new request ignored until the result is taken
        bus.data_valid_in = 1'b1;
        bus.mode_dec_in   = 1'b0;
        bus.key_in        = K1;
        bus.data_in       = PT1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("hold_res", bus.res_out, PT1);
            chk("hold_valid", 128'(bus.res_valid_out), 128'd1);
            chk("hold_ready", 128'(bus.data_ready_out), 128'd0);
        end
        bus.res_ready_in = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready_in = 1'b0;
        chk("release_valid", 128'(bus.res_valid_out), 128'd0);
        chk("release_ready", 128'(bus.data_ready_out), 128'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        chk("next_accepted", 128'(bus.data_ready_out), 128'd0);
        bus.data_valid_in = 1'b0;
        bus.key_in        = 'x;
        bus.data_in       = 'x;
        bus.mode_dec_in   = 1'bx;
        sb.push_back('{CT1, 10});
        wait_res("enc_after_hold");
        consume("enc_after_hold");

        // res_ready_in held high while idle/busy has no effect until a result exists
        bus.res_ready_in = 1'b1;
        send(1'b0, K1, PT1, CT1, 10, 1'b1);
        wait_res("enc_ready_early");
        @(posedge clk);
        #1;
        bus.res_ready_in = 1'b0;
        chk("early_consumed", 128'(bus.res_valid_out), 128'd0);
        chk("sb_drained", 128'(sb.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
